pixel_ctrl_axil_slave: RTL and testbench
========================================

# pixel_ctrl_axil_slave

AXI4-Lite responder that terminates the S00_AXI control port of the pixelDataToVideoStream IP. It owns four 32-bit software registers, drives their contents to the pixel datapath, and emits a one-cycle strobe when the pixel-data register is written. It is the slave end of the master VIP transactions the IP's BFM bench issues: sequential writes of 1..4 to 0x0..0xC followed by read-back.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6, byte address width; 16 word slots, of which 4 are implemented.
- S_AXI_ACLK  in  1  single clock.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR/AWPROT/AWVALID  in  6/3/1  write address channel; AWPROT is ignored.
- S_AXI_AWREADY  out  1
- S_AXI_WDATA/WSTRB/WVALID  in  32/4/1  write data channel.
- S_AXI_WREADY  out  1
- S_AXI_BRESP/BVALID  out  2/1 ; S_AXI_BREADY  in  1
- S_AXI_ARADDR/ARPROT/ARVALID  in  6/3/1 ; S_AXI_ARREADY  out  1
- S_AXI_RDATA/RRESP/RVALID  out  32/2/1 ; S_AXI_RREADY  in  1
- ctrl_o  out  32  register 0 (bit0 = stream enable).
- pixel_o  out  32  register 1.
- cfg0_o, cfg1_o  out  32  registers 2 and 3.
- pixel_wr_stb_o  out  1  one-cycle pulse after any committed write to register 1.

## Operation
- Word index = ADDR[5:2]; ADDR[1:0] is ignored.
- Write path:
  - AW and W are latched independently into holding registers. AWREADY is high while no address is held and BVALID is low; WREADY follows the same rule for data.
  - The write commits in the first cycle both are held. Byte lanes are gated by WSTRB; a zero WSTRB commits nothing but still completes with a response.
  - BVALID rises the cycle after commit. The holding registers clear at commit. BVALID and BRESP stay stable until BREADY.
- Read path:
  - ARREADY is high while RVALID is low.
  - On AR handshake, RDATA and RRESP load in the same edge, so RVALID rises the next cycle.
  - RDATA and RRESP stay stable until RREADY.
- Simultaneous AR accept and write commit to the same register: read returns the pre-write value.
- Reset: all registers, holding registers, BVALID, RVALID, RDATA, pixel_wr_stb_o = 0; AWREADY/WREADY/ARREADY = 0 while ARESETN is low, then 1 from the first edge after release. Reset mid-transaction drops the transaction with no response.

## Timing
- Write with AW and W in the same cycle (cycle N): commit and strobe at N+1, BVALID at N+1. Throughput is one write per 2 cycles when BREADY is held high.
- W arriving k cycles after AW: commit one cycle after the W handshake.
- Read: AR handshake at N, RVALID at N+1. Throughput is one read per 2 cycles.
- BRESP/RRESP = OKAY (2'b00) unless the macro below applies.

## Configuration
- PIXCTRL_SLVERR_EN defined:
  - Word indices 4..15 respond SLVERR (2'b10).
  - Writes to those indices commit nothing; reads return 0.
- Undefined:
  - Indices alias modulo 4 (index[1:0]) and always respond OKAY.

## Structure
- Package pixel_ctrl_pkg: RESP_OKAY/RESP_SLVERR constants, register index constants (REG_CTRL=0, REG_PIXEL=1, REG_CFG0=2, REG_CFG1=3), NUM_REGS=4.
- One sub-module, pixel_ctrl_regfile: the byte-strobed register array with write port and combinational read mux. The channel handshakes stay in the top module.

## Test plan
- Write 0x1,0x2,0x3,0x4 to 0x0/0x4/0x8/0xC, then read back -> RDATA 0x1..0x4, all RRESP OKAY; ctrl_o=1, pixel_o=2.
- W presented 3 cycles before AW to 0x4 with data 0xAABBCCDD -> single commit, pixel_wr_stb_o pulses exactly once, BVALID one cycle after the AW handshake.
- WSTRB=4'b0010, data 0xFFFFFFFF to 0x8 holding 0 -> cfg0_o=0x0000FF00.
- BREADY held low 10 cycles after a write -> BVALID held, AWREADY/WREADY low, a second AW not accepted until the B handshake.
- Read 0x20: with PIXCTRL_SLVERR_EN -> RRESP=2'b10, RDATA=0; without -> OKAY, RDATA equals register 0.
- ARESETN deasserted with BVALID pending -> all outputs 0 next sample. After release, a write/read of 0x5 to 0x0 succeeds.

Source files
------------

// File: rtl/pixel_ctrl_pkg.sv
// pixel_ctrl_pkg: response codes, register map and byte-lane merge shared by the pixel control slave.
package pixel_ctrl_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int NUM_REGS = 4;
    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_PIXEL = 2'd1;
    localparam logic [1:0] REG_CFG0  = 2'd2;
    localparam logic [1:0] REG_CFG1  = 2'd3;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_d, input logic [31:0] new_d,
                                               input logic [3:0] strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? new_d[8*i +: 8] : old_d[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/pixel_ctrl_regfile.sv
// pixel_ctrl_regfile: four byte-strobed 32-bit registers with one write port and a combinational read mux.
module pixel_ctrl_regfile
    import pixel_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [1:0]  widx,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic [1:0]  ridx,
    output logic [31:0] rdata,
    output logic [31:0] ctrl,
    output logic [31:0] pixel,
    output logic [31:0] cfg0,
    output logic [31:0] cfg1
);
    logic [31:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[widx] <= apply_strb(regs[widx], wdata, wstrb);
        end
    end

    // Reads see the pre-edge contents, so a same-cycle write is not visible yet.
    assign rdata = regs[ridx];
    assign ctrl  = regs[REG_CTRL];
    assign pixel = regs[REG_PIXEL];
    assign cfg0  = regs[REG_CFG0];
    assign cfg1  = regs[REG_CFG1];
endmodule

// File: rtl/pixel_ctrl_axil_slave.sv
// pixel_ctrl_axil_slave: AXI4-Lite slave owning the pixel datapath control registers.
// Define PIXCTRL_SLVERR_EN to answer word indices 4..15 with SLVERR instead of aliasing them.
module pixel_ctrl_axil_slave
    import pixel_ctrl_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [31:0]                     ctrl_o,
    output logic [31:0]                     pixel_o,
    output logic [31:0]                     cfg0_o,
    output logic [31:0]                     cfg1_o,
    output logic                            pixel_wr_stb_o
);
    localparam int IW = C_S_AXI_ADDR_WIDTH - 2;

    logic          ready_en, aw_held, w_held;
    logic [IW-1:0] aw_idx, c_idx, r_idx;
    logic [31:0]   w_data, c_data, rf_rdata;
    logic [3:0]    w_strb, c_strb;
    logic          aw_hs, w_hs, ar_hs, commit, w_ok, r_ok, wr_en;
    logic          unused_ok;

    assign S_AXI_AWREADY = ready_en & ~aw_held & ~S_AXI_BVALID;
    assign S_AXI_WREADY  = ready_en & ~w_held & ~S_AXI_BVALID;
    assign S_AXI_ARREADY = ready_en & ~S_AXI_RVALID;
    assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

    // Commit on the edge where the second half of the pair arrives, using the live channel if not yet held.
    assign commit = (aw_held | aw_hs) & (w_held | w_hs);
    assign c_idx  = aw_held ? aw_idx : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign c_data = w_held ? w_data : S_AXI_WDATA;
    assign c_strb = w_held ? w_strb : S_AXI_WSTRB;
    assign r_idx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

`ifdef PIXCTRL_SLVERR_EN
    assign w_ok = ~|c_idx[IW-1:2];
    assign r_ok = ~|r_idx[IW-1:2];
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`else
    assign w_ok = 1'b1;
    assign r_ok = 1'b1;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                         c_idx[IW-1:2], r_idx[IW-1:2]};
`endif

    assign wr_en = commit & w_ok;

    pixel_ctrl_regfile u_regfile (
        .clk   (S_AXI_ACLK),
        .rst_n (S_AXI_ARESETN),
        .we    (wr_en),
        .widx  (c_idx[1:0]),
        .wdata (c_data),
        .wstrb (c_strb),
        .ridx  (r_idx[1:0]),
        .rdata (rf_rdata),
        .ctrl  (ctrl_o),
        .pixel (pixel_o),
        .cfg0  (cfg0_o),
        .cfg1  (cfg1_o)
    );

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ready_en <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx   <= '0;
            w_data   <= '0;
            w_strb   <= '0;
        end else begin
            ready_en <= 1'b1;
            aw_held  <= (aw_held | aw_hs) & ~commit;
            w_held   <= (w_held | w_hs) & ~commit;
            if (aw_hs) aw_idx <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            if (w_hs) begin
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_BVALID   <= 1'b0;
            S_AXI_BRESP    <= RESP_OKAY;
            pixel_wr_stb_o <= 1'b0;
        end else begin
            pixel_wr_stb_o <= wr_en & |c_strb & (c_idx[1:0] == REG_PIXEL);
            if (commit) begin
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= w_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RRESP  <= RESP_OKAY;
        end else if (ar_hs) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA  <= r_ok ? rf_rdata : '0;
            S_AXI_RRESP  <= r_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pixel_ctrl_axil_slave.sv
// tb_pixel_ctrl_axil_slave: directed bench for the pixel control AXI4-Lite slave.
module tb_pixel_ctrl_axil_slave;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid, stb;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, ctrl_o, pixel_o, cfg0_o, cfg1_o;
    int          n_checks = 0, n_fail = 0;
    logic [31:0] rd;
    logic [1:0]  rsp;

    always #5 clk = ~clk;

    pixel_ctrl_axil_slave dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (3'b000),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (3'b000),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .ctrl_o        (ctrl_o),
        .pixel_o       (pixel_o),
        .cfg0_o        (cfg0_o),
        .cfg1_o        (cfg1_o),
        .pixel_wr_stb_o(stb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int n;
        logic aw_ok, w_ok;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            aw_ok = awvalid && awready;
            w_ok  = wvalid && wready;
            tick();
            if (aw_ok) awvalid = 1'b0;
            if (w_ok) wvalid = 1'b0;
            n++;
        end
        bready = 1'b1; n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        chk("b_wait", bvalid, 1);
        resp = bresp;
        tick();
        bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        logic ok;
        araddr = a; arvalid = 1'b1; n = 0;
        while (arvalid && n < 20) begin
            ok = arready;
            tick();
            if (ok) arvalid = 1'b0;
            n++;
        end
        rready = 1'b1; n = 0;
        while (!rvalid && n < 20) begin tick(); n++; end
        chk("r_wait", rvalid, 1);
        d = rdata; resp = rresp;
        tick();
        rready = 1'b0; arvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and ready release
        repeat (3) tick();
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_ctrl", ctrl_o, 0);
        rst_n = 1'b1;
        chk("rel_awready_low", awready, 0);
        tick();
        chk("rel_awready", awready, 1);
        chk("rel_arready", arready, 1);

        // Sequential writes of 1..4 and read-back
        for (int i = 0; i < 4; i++) begin
            axi_write(6'(4 * i), 32'(i + 1), 4'hF, rsp);
            chk("wr_bresp", 32'(rsp), 0);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(6'(4 * i), rd, rsp);
            chk("rd_data", rd, 32'(i + 1));
            chk("rd_rresp", 32'(rsp), 0);
        end
        chk("ctrl_o", ctrl_o, 32'h1);
        chk("pixel_o", pixel_o, 32'h2);
        chk("cfg0_o", cfg0_o, 32'h3);
        chk("cfg1_o", cfg1_o, 32'h4);

        // W leads AW by 3 cycles
        wdata = 32'hAABBCCDD; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("wlead_wready_held", wready, 0);
        chk("wlead_no_b", bvalid, 0);
        tick();
        chk("wlead_stb0a", stb, 0);
        tick();
        chk("wlead_stb0b", stb, 0);
        chk("wlead_pixel_old", pixel_o, 32'h2);
        awaddr = 6'h4; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("wlead_bvalid", bvalid, 1);
        chk("wlead_stb1", stb, 1);
        chk("wlead_pixel", pixel_o, 32'hAABBCCDD);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("wlead_stb_once", stb, 0);
        chk("wlead_b_done", bvalid, 0);

        // Byte strobe on register 2
        axi_write(6'h8, 32'h0, 4'hF, rsp);
        axi_write(6'h8, 32'hFFFFFFFF, 4'b0010, rsp);
        chk("strb_cfg0", cfg0_o, 32'h0000FF00);
        chk("strb_bresp", 32'(rsp), 0);

        // BREADY held low blocks the next write
        awaddr = 6'hC; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        chk("bp_bvalid0", bvalid, 1);
        awaddr = 6'h0; wdata = 32'h7; awvalid = 1'b1; wvalid = 1'b1;
        repeat (10) tick();
        chk("bp_bvalid_held", bvalid, 1);
        chk("bp_awready", awready, 0);
        chk("bp_wready", wready, 0);
        chk("bp_ctrl_unchanged", ctrl_o, 32'h1);
        chk("bp_cfg1", cfg1_o, 32'h55);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("bp_b_done", bvalid, 0);
        chk("bp_awready_back", awready, 1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bp_second_b", bvalid, 1);
        chk("bp_ctrl_new", ctrl_o, 32'h7);
        bready = 1'b1;
        tick();
        bready = 1'b0;

        // Out-of-map index 8
        axi_read(6'h20, rd, rsp);
`ifdef PIXCTRL_SLVERR_EN
        chk("oob_rresp", 32'(rsp), 32'h2);
        chk("oob_rdata", rd, 32'h0);
`else
        chk("oob_rresp", 32'(rsp), 32'h0);
        chk("oob_rdata", rd, 32'h7);
`endif

        // Reset with a pending write response
        awaddr = 6'h0; wdata = 32'h9; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("mid_bvalid", bvalid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bvalid", bvalid, 0);
        chk("mid_rst_ctrl", ctrl_o, 0);
        chk("mid_rst_pixel", pixel_o, 0);
        chk("mid_rst_cfg0", cfg0_o, 0);
        chk("mid_rst_cfg1", cfg1_o, 0);
        chk("mid_rst_awready", awready, 0);
        chk("mid_rst_arready", arready, 0);
        chk("mid_rst_rdata", rdata, 0);
        chk("mid_rst_stb", stb, 0);
        tick();
        rst_n = 1'b1;
        tick();
        axi_write(6'h0, 32'h5, 4'hF, rsp);
        chk("post_bresp", 32'(rsp), 0);
        axi_read(6'h0, rd, rsp);
        chk("post_rdata", rd, 32'h5);
        chk("post_rresp", 32'(rsp), 0);

        // Read and write to the same register on the same edge
        awaddr = 6'h4; wdata = 32'h99; wstrb = 4'hF; araddr = 6'h4;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("rw_rvalid", rvalid, 1);
        chk("rw_rdata_old", rdata, 32'h0);
        chk("rw_bvalid", bvalid, 1);
        chk("rw_pixel_new", pixel_o, 32'h99);
        chk("rw_stb", stb, 1);
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        chk("rw_idle_b", bvalid, 0);
        chk("rw_idle_r", rvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
